out_display_seq: RTL and testbench
==================================

# out_display_seq

Parametrised successor to the combinational output stage. It accepts a WIDTH-bit value, signed or unsigned. A sequential double-dabble engine converts it to DIGITS BCD digits plus a sign. The result is held in registers that drive the seven-segment displays. It sits between the core's output register and the board displays, updates the displays only when a conversion completes (no intermediate flicker), and reports progress with a busy/done handshake.

## Interface
- WIDTH, 9: input data width (2..32).
- DIGITS, 3: number of decimal digit displays. Must satisfy 10^DIGITS > 2^WIDTH; otherwise the design fails elaboration (generate-time check).
- SIGNED, 1: 1 = dataIn is two's complement; 0 = unsigned.

- clock  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dataIn  in  WIDTH  value to convert; sampled only on the accepted load edge.
- load  in  1  start request; accepted only when busy=0.
- halt  in  1  display blanking request.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when the displays take a new result.
- display  out  7*DIGITS  digit i occupies [7i+6:7i]; digit 0 = units. Segment order {g,f,e,d,c,b,a}; segments are active-low.
- displaySign  out  7  7'b0111111 ('-') when the latched value is negative, else 7'h7F (off).

## Operation
- The FSM has three states: IDLE, CONVERT, UPDATE.
- IDLE, load=1:
  - Capture sign = SIGNED & dataIn[WIDTH-1].
  - Capture magnitude = sign ? -dataIn : dataIn, computed in WIDTH bits. The most-negative value gives magnitude 2^(WIDTH-1), which fits unsigned.
  - Clear the BCD accumulator, set the bit counter to WIDTH, go to CONVERT.
- CONVERT, each cycle:
  - Add 3 to every BCD nibble that is ≥5.
  - Shift {bcd, magnitude} left by 1 and decrement the counter.
  - When the counter reaches 0, go to UPDATE.
- UPDATE:
  - Encode each BCD nibble into display registers: 0..9 use the standard glyphs.
  - Latch sign into the sign register.
  - Pulse done and return to IDLE.
- Display and sign registers change only in UPDATE.
- load while busy=1 is ignored. It is not queued.
- halt forces display and displaySign to all-ones (blank), combinationally. Stored registers are unaffected, so deasserting halt restores the last result immediately. halt does not stall conversion.
- SIGNED=0: sign is always 0 and displaySign is always off.

## Timing
- Reset values:
  - busy=0, done=0, FSM=IDLE.
  - Digit 0 = "0" (7'b1000000).
  - Digits 1..DIGITS-1 = "0", or blank when the blanking feature is enabled.
  - displaySign = 7'h7F.
- load accepted at edge k:
  - busy=1 from k.
  - CONVERT occupies edges k+1..k+WIDTH.
  - UPDATE is at edge k+WIDTH+1: display changes and done=1 for that single cycle, busy=0 after it.
- Latency from load to new display is WIDTH+1 cycles; throughput is one conversion per WIDTH+2 cycles.
- load held high continuously restarts a conversion on the first IDLE cycle after UPDATE.
- reset_n asserted mid-conversion aborts immediately: all outputs return to their reset values asynchronously, and the partial result is discarded.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digits above the most significant non-zero digit are blanked (7'h7F). Digit 0 is never blanked, so 0 shows as a single "0". The '-' stays on displaySign; it does not move adjacent to the number.
- LEADING_ZERO_BLANK_EN undefined: all DIGITS digits show, including leading zeros (e.g. "007").

## Test plan
- WIDTH=9, SIGNED=1, dataIn=9'h100 (-256), load pulse:
  - busy for 10 cycles, done pulse at edge k+10.
  - Digits 2,5,6 = 7'b0100100, 7'b0010010, 7'b0000010.
  - displaySign=7'b0111111.
- dataIn=9'h0FF (255):
  - Digits 2,5,5; sign off.
  - Then dataIn=0: units "0"; upper digits "0", or blank with LEADING_ZERO_BLANK_EN.
- Second load pulse 3 cycles into a conversion:
  - Ignored; the result reflects the first dataIn only; exactly one done pulse.
- halt=1 after a result of 123:
  - All display bits 1 and displaySign 7'h7F.
  - halt=0 restores "123" in the same cycle.
- reset_n low at cycle 4 of a conversion:
  - Outputs go to reset values immediately; busy=0, no done pulse.
  - A subsequent load converts correctly.
- SIGNED=0, dataIn=9'h1FF: shows 511 with the sign off.

Source files
------------

// File: rtl/out_display_seq.sv
// Sequential binary-to-seven-segment stage: latches a WIDTH-bit value, converts it to BCD
// with a bit-serial double-dabble, and shows it on DIGITS displays. Optional: LEADING_ZERO_BLANK_EN.
module out_display_seq #(
   parameter int WIDTH  = 9,
   parameter int DIGITS = 3,
   parameter bit SIGNED = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [WIDTH-1:0]      dataIn,
   input  logic                  load,
   input  logic                  halt,
   output logic                  busy,
   output logic                  done,
   output logic [7*DIGITS-1:0]   display,
   output logic [6:0]            displaySign
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int BCD_W = 4 * DIGITS;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CONVERT = 2'd1;
   localparam logic [1:0] UPDATE  = 2'd2;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] SEG_UPPER_RST = SEG_BLANK;
`else
   localparam logic [6:0] SEG_UPPER_RST = SEG_ZERO;
`endif

   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   function automatic logic [7*DIGITS-1:0] disp_reset();
      logic [7*DIGITS-1:0] r;
      r = {(7*DIGITS){1'b1}};
      for (int i = 0; i < DIGITS; i++) begin
         r[7*i +: 7] = (i == 0) ? SEG_ZERO : SEG_UPPER_RST;
      end
      return r;
   endfunction

   localparam logic [7*DIGITS-1:0] DISP_RST = disp_reset();

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Nibbles of 5 or more get +3 so the following left shift carries correctly into the next decade.
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (b[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = b[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = b[4*i +: 4];
         end
      end
      return r;
   endfunction

   generate
      if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
         $error("out_display_seq: WIDTH must be in 2..32");
      end
      if (pow10(DIGITS) <= (64'd1 << WIDTH)) begin : g_bad_digits
         $error("out_display_seq: DIGITS too small for WIDTH (need 10^DIGITS > 2^WIDTH)");
      end
   endgenerate

   logic [1:0]            state;
   logic [CNT_W-1:0]      cnt;
   logic [BCD_W-1:0]      bcd;
   logic [WIDTH-1:0]      mag;
   logic                  sign_cap;
   logic [7*DIGITS-1:0]   display_reg;
   logic [6:0]            sign_reg;
   logic                  busy_reg;
   logic                  done_reg;
   logic                  load_neg;
   logic [7*DIGITS-1:0]   disp_next;

   assign load_neg = SIGNED & dataIn[WIDTH-1];

   // Glyph image of the finished BCD value, with optional leading-zero blanking.
`ifdef LEADING_ZERO_BLANK_EN
   logic nz_seen;
   always_comb begin
      nz_seen   = 1'b0;
      disp_next = {(7*DIGITS){1'b1}};
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (bcd[4*i +: 4] != 4'd0) begin
            nz_seen = 1'b1;
         end else begin
            nz_seen = nz_seen;
         end
         if (i == 0 || nz_seen) begin
            disp_next[7*i +: 7] = seg_encode(bcd[4*i +: 4]);
         end else begin
            disp_next[7*i +: 7] = SEG_BLANK;
         end
      end
   end
`else
   always_comb begin
      disp_next = {(7*DIGITS){1'b1}};
      for (int i = 0; i < DIGITS; i++) begin
         disp_next[7*i +: 7] = seg_encode(bcd[4*i +: 4]);
      end
   end
`endif

   // Conversion sequencer; display and sign registers only move in UPDATE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         bcd         <= '0;
         mag         <= '0;
         sign_cap    <= 1'b0;
         display_reg <= DISP_RST;
         sign_reg    <= SEG_BLANK;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  sign_cap <= load_neg;
                  mag      <= load_neg ? (~dataIn) + WIDTH'(1) : dataIn;
                  bcd      <= '0;
                  cnt      <= CNT_W'(WIDTH);
                  busy_reg <= 1'b1;
                  state    <= CONVERT;
               end
            end
            CONVERT: begin
               {bcd, mag} <= {bcd_adjust(bcd), mag} << 1;
               cnt        <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               display_reg <= disp_next;
               sign_reg    <= sign_cap ? SEG_MINUS : SEG_BLANK;
               done_reg    <= 1'b1;
               busy_reg    <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               busy_reg <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   // Blanking is purely an output override so the held result reappears as soon as halt drops.
   assign display     = halt ? {(7*DIGITS){1'b1}} : display_reg;
   assign displaySign = halt ? SEG_BLANK : sign_reg;

endmodule

// File: tb/tb_out_display_seq.sv
// Directed bench for out_display_seq: a decimal-arithmetic reference model is checked every
// cycle against a signed and an unsigned instance, plus hand-computed glyph expectations.
module tb_out_display_seq;

   localparam int WIDTH  = 9;
   localparam int DIGITS = 3;

   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] G6 = 7'b0000010;
   localparam logic [6:0] BL = 7'h7F;
   localparam logic [6:0] MI = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] ZU = BL;
`else
   localparam logic [6:0] ZU = G0;
`endif

   localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                         7'b0000000, 7'b0010000};

   logic                clock = 1'b0;
   logic                reset_n = 1'b0;
   logic [WIDTH-1:0]    dataIn = '0;
   logic                load = 1'b0;
   logic                halt = 1'b0;
   logic                busy_s, done_s, busy_u, done_u;
   logic [7*DIGITS-1:0] display_s, display_u;
   logic [6:0]          sign_s, sign_u;

   int n_checks = 0;
   int n_errors = 0;
   int busy_cnt = 0;
   int done_cnt = 0;
   int cyc = 0;
   int last_done = 0;
   int prev_done = 0;

   always #5 clock = ~clock;

   out_display_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SIGNED(1'b1)) u_sgn (
      .clock(clock), .reset_n(reset_n), .dataIn(dataIn), .load(load), .halt(halt),
      .busy(busy_s), .done(done_s), .display(display_s), .displaySign(sign_s));

   out_display_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SIGNED(1'b0)) u_uns (
      .clock(clock), .reset_n(reset_n), .dataIn(dataIn), .load(load), .halt(halt),
      .busy(busy_u), .done(done_u), .display(display_u), .displaySign(sign_u));

   // Decimal rendering of a value straight from its integer meaning.
   function automatic logic [7*DIGITS-1:0] model_disp(input logic [WIDTH-1:0] v, input bit sgn);
      int val, mag, m0, p;
      logic [7*DIGITS-1:0] r;
      val = sgn ? int'($signed(v)) : int'(v);
      mag = (val < 0) ? -val : val;
      m0  = mag;
      p   = 1;
      r   = '1;
      for (int i = 0; i < DIGITS; i++) begin
         r[7*i +: 7] = GLYPH[mag % 10];
`ifdef LEADING_ZERO_BLANK_EN
         if (i > 0 && m0 < p) r[7*i +: 7] = BL;
`endif
         mag = mag / 10;
         p   = p * 10;
      end
      return r;
   endfunction

   // Timing model: a conversion is a WIDTH+1 cycle countdown, result appears when it expires.
   int                  m_cnt;
   logic [WIDTH-1:0]    m_val;
   logic                m_done;
   logic [7*DIGITS-1:0] m_disp_s, m_disp_u;
   logic [6:0]          m_sign_s;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_cnt    <= 0;
         m_val    <= '0;
         m_done   <= 1'b0;
         m_disp_s <= model_disp('0, 1'b0);
         m_disp_u <= model_disp('0, 1'b0);
         m_sign_s <= BL;
      end else begin
         m_done <= 1'b0;
         if (m_cnt == 0) begin
            if (load) begin
               m_cnt <= WIDTH + 1;
               m_val <= dataIn;
            end
         end else begin
            if (m_cnt == 1) begin
               m_disp_s <= model_disp(m_val, 1'b1);
               m_disp_u <= model_disp(m_val, 1'b0);
               m_sign_s <= ($signed(m_val) < 0) ? MI : BL;
               m_done   <= 1'b1;
            end
            m_cnt <= m_cnt - 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [7*DIGITS-1:0] eds, edu;
      logic [6:0]          ess;
      eds = halt ? '1 : m_disp_s;
      edu = halt ? '1 : m_disp_u;
      ess = halt ? BL : m_sign_s;
      check("cyc_busy_s", 32'(busy_s), 32'(m_cnt != 0));
      check("cyc_done_s", 32'(done_s), 32'(m_done));
      check("cyc_disp_s", 32'(display_s), 32'(eds));
      check("cyc_sign_s", 32'(sign_s), 32'(ess));
      check("cyc_busy_u", 32'(busy_u), 32'(m_cnt != 0));
      check("cyc_done_u", 32'(done_u), 32'(m_done));
      check("cyc_disp_u", 32'(display_u), 32'(edu));
      check("cyc_sign_u", 32'(sign_u), 32'(BL));
   endtask

   task automatic start(input logic [WIDTH-1:0] v);
      @(negedge clock); #1;
      dataIn = v;
      load   = 1'b1;
      @(negedge clock); #1;
      load   = 1'b0;
   endtask

   task automatic wait_done(input int base, input int budget);
      int n;
      n = 0;
      while (done_cnt == base && n < budget) begin
         @(negedge clock); #1;
         n++;
      end
      check("done_timeout", 32'(done_cnt != base), 32'd1);
   endtask

   initial begin
      int b0, d0;
      repeat (2) @(negedge clock);
      #1;
      check("rst_busy", 32'(busy_s), 32'd0);
      check("rst_done", 32'(done_s), 32'd0);
      check("rst_disp", 32'(display_s), 32'({ZU, ZU, G0}));
      check("rst_sign", 32'(sign_s), 32'(BL));
      fork
         forever begin
            @(negedge clock);
            cyc++;
            if (busy_s) busy_cnt++;
            if (done_s) begin
               done_cnt++;
               prev_done = last_done;
               last_done = cyc;
            end
            compare_all();
         end
      join_none
      reset_n = 1'b1;

      // -256: most negative value
      b0 = busy_cnt; d0 = done_cnt;
      start(9'h100);
      wait_done(d0, 30);
      check("neg256_busy_cycles", 32'(busy_cnt - b0), 32'd10);
      check("neg256_disp", 32'(display_s), 32'({G2, G5, G6}));
      check("neg256_sign", 32'(sign_s), 32'(MI));

      d0 = done_cnt;
      start(9'h0FF);
      wait_done(d0, 30);
      check("p255_disp", 32'(display_s), 32'({G2, G5, G5}));
      check("p255_sign", 32'(sign_s), 32'(BL));

      d0 = done_cnt;
      start(9'h000);
      wait_done(d0, 30);
      check("zero_disp", 32'(display_s), 32'({ZU, ZU, G0}));

      // second load during a conversion must be dropped
      d0 = done_cnt;
      start(9'h07B);
      @(negedge clock); #1;
      dataIn = 9'h1C8; load = 1'b1;
      @(negedge clock); #1;
      load = 1'b0;
      wait_done(d0, 30);
      repeat (15) @(negedge clock);
      #1;
      check("ignore_one_done", 32'(done_cnt - d0), 32'd1);
      check("ignore_disp", 32'(display_s), 32'({G1, G2, G3}));

      halt = 1'b1;
      #1;
      check("halt_disp", 32'(display_s), 32'({(7*DIGITS){1'b1}}));
      check("halt_sign", 32'(sign_s), 32'(BL));
      repeat (2) @(negedge clock);
      #1;
      halt = 1'b0;
      #1;
      check("unhalt_disp", 32'(display_s), 32'({G1, G2, G3}));

      // asynchronous abort mid-conversion
      d0 = done_cnt;
      start(9'h1FB);
      repeat (3) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy_s), 32'd0);
      check("abort_done", 32'(done_s), 32'd0);
      check("abort_disp", 32'(display_s), 32'({ZU, ZU, G0}));
      check("abort_sign", 32'(sign_s), 32'(BL));
      @(negedge clock); #1;
      reset_n = 1'b1;
      repeat (15) @(negedge clock);
      #1;
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      check("abort_idle", 32'(busy_s), 32'd0);
      d0 = done_cnt;
      start(9'h1FB);
      wait_done(d0, 30);
      check("neg5_disp", 32'(display_s), 32'({ZU, ZU, G5}));
      check("neg5_sign", 32'(sign_s), 32'(MI));

      d0 = done_cnt;
      start(9'h1FF);
      wait_done(d0, 30);
      check("uns511_disp", 32'(display_u), 32'({G5, G1, G1}));
      check("uns511_sign", 32'(sign_u), 32'(BL));
      check("sgn_m1_disp", 32'(display_s), 32'({ZU, ZU, G1}));
      check("sgn_m1_sign", 32'(sign_s), 32'(MI));

      // load held high: back-to-back conversions every WIDTH+2 cycles
      d0 = done_cnt;
      @(negedge clock); #1;
      dataIn = 9'h02A; load = 1'b1;
      wait_done(d0, 30);
      wait_done(d0 + 1, 30);
      load = 1'b0;
      check("held_spacing", 32'(last_done - prev_done), 32'(WIDTH + 2));
      repeat (3) @(negedge clock);
      #1;
      check("held_idle", 32'(busy_s), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
